// File: rtl/trax_move_tx.sv
// TRAX move transmitter: converts a 22-bit move word to ASCII Trax notation and sends it as UART 8N1.
// Define TRAX_MOVE_TX_NEWLINE_EN to append a line-feed (0x0A) terminator to every move.
module trax_move_tx #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_transmit,
  input  logic [21:0] move_in,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, CONVERT, LOAD, SEND, DONE} state_t;

  localparam logic [15:0] TIMER_MAX = 16'(CLKS_PER_BIT - 1);

  state_t      state, state_n;
  logic [9:0]  bin_q, bin_n;
  logic [15:0] bcd_q, bcd_n, bcd_adj;
  logic [3:0]  cnt_q, cnt_n;
  logic [1:0]  tile_q, tile_n;
  logic [4:0]  col_q, col_n;
  logic [55:0] frame_q, frame_n, load_frame;
  logic [2:0]  left_q, left_n, load_n, ndig;
  logic [15:0] timer_q, timer_n;
  logic [3:0]  idx_q, idx_n;
  logic [7:0]  tile_char;
  logic        tx_n, busy_n, done_n, err_n, illegal;

  function automatic logic bit_of(input logic [3:0] idx, input logic [7:0] ch);
    if (idx == 4'd0)      return 1'b0;
    else if (idx >= 4'd9) return 1'b1;
    else                  return ch[3'(idx - 4'd1)];
  endfunction

  assign illegal = (move_in[21:20] == 2'd3) || (move_in[9:0] > 10'd26);

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 4; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  // Character list is packed LSB-first so SEND can shift out one byte per character.
  always_comb begin
    load_frame = '0;
    if (bcd_q[15:12] != 4'd0)    ndig = 3'd4;
    else if (bcd_q[11:8] != 4'd0) ndig = 3'd3;
    else if (bcd_q[7:4] != 4'd0)  ndig = 3'd2;
    else                          ndig = 3'd1;
    case (tile_q)
      2'd0:    tile_char = 8'h2B;
      2'd1:    tile_char = 8'h2F;
      default: tile_char = 8'h5C;
    endcase
    load_frame[7:0] = 8'h40 + {3'b000, col_q};
    for (int unsigned i = 0; i < 4; i++)
      if (i < 32'(ndig))
        load_frame[8*(i+1) +: 8] = {4'h3, bcd_q[4*(32'(ndig) - 1 - i) +: 4]};
    load_frame[8*(32'(ndig) + 1) +: 8] = tile_char;
`ifdef TRAX_MOVE_TX_NEWLINE_EN
    load_frame[8*(32'(ndig) + 2) +: 8] = 8'h0A;
    load_n = ndig + 3'd3;
`else
    load_n = ndig + 3'd2;
`endif
  end

  always_comb begin
    state_n = state;
    bin_n   = bin_q;
    bcd_n   = bcd_q;
    cnt_n   = cnt_q;
    tile_n  = tile_q;
    col_n   = col_q;
    frame_n = frame_q;
    left_n  = left_q;
    timer_n = timer_q;
    idx_n   = idx_q;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start_transmit) begin
          if (illegal) begin
            err_n = 1'b1;
          end else begin
            state_n = CONVERT;
            bin_n   = move_in[19:10];
            bcd_n   = '0;
            cnt_n   = '0;
            tile_n  = move_in[21:20];
            col_n   = move_in[4:0];
          end
        end
      end
      CONVERT: begin
        {bcd_n, bin_n} = {bcd_adj, bin_q} << 1;
        cnt_n = cnt_q + 4'd1;
        if (cnt_q == 4'd9) state_n = LOAD;
      end
      LOAD: begin
        frame_n = load_frame;
        left_n  = load_n;
        timer_n = '0;
        idx_n   = '0;
        state_n = SEND;
      end
      SEND: begin
        if (timer_q == TIMER_MAX) begin
          timer_n = '0;
          if (idx_q == 4'd9) begin
            idx_n = '0;
            if (left_q == 3'd1) begin
              state_n = DONE;
            end else begin
              left_n  = left_q - 3'd1;
              frame_n = frame_q >> 8;
            end
          end else begin
            idx_n = idx_q + 4'd1;
          end
        end else begin
          timer_n = timer_q + 16'd1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    tx_n   = (state_n == SEND) ? bit_of(idx_n, frame_n[7:0]) : 1'b1;
    busy_n = state_n inside {CONVERT, LOAD, SEND};
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      tile_q  <= '0;
      col_q   <= '0;
      frame_q <= '0;
      left_q  <= '0;
      timer_q <= '0;
      idx_q   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      bin_q   <= bin_n;
      bcd_q   <= bcd_n;
      cnt_q   <= cnt_n;
      tile_q  <= tile_n;
      col_q   <= col_n;
      frame_q <= frame_n;
      left_q  <= left_n;
      timer_q <= timer_n;
      idx_q   <= idx_n;
      tx      <= tx_n;
      busy    <= busy_n;
      done    <= done_n;
      err     <= err_n;
    end
  end

endmodule

// File: tb/tb_trax_move_tx.sv
// Scoreboard bench for trax_move_tx: a UART monitor pops expected ASCII bytes; the main thread checks timing.
module tb_trax_move_tx;
  localparam int unsigned C = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_transmit = 1'b0;
  logic [21:0] move_in = '0;
  logic        tx, busy, done, err;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];
  int          abort_gen = 0;
  int          mon_gen;
  int          byte_no = 0;
  bit          mon_en = 1'b0;

  trax_move_tx #(.CLKS_PER_BIT(C)) dut (
    .clock(clock), .reset(reset), .start_transmit(start_transmit), .move_in(move_in),
    .tx(tx), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // UART receiver: samples mid-bit on falling edges, discards bytes cut short by reset.
  initial begin
    logic [7:0] b;
    logic       stopb;
    forever begin
      @(negedge clock);
      if (mon_en && tx === 1'b0) begin
        mon_gen = abort_gen;
        repeat (C + C/2) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          b[i] = tx;
          repeat (C) @(negedge clock);
        end
        stopb = tx;
        if (mon_gen == abort_gen) begin
          check("stop_bit", stopb, 1);
          if (exp_q.size() == 0) check("sb_nonempty", exp_q.size(), 1);
          else check($sformatf("byte%0d", byte_no), b, exp_q.pop_front());
          byte_no++;
        end
      end
    end
  end

  task automatic push_exp(input logic [21:0] mv, output int n);
    string cols, digs;
    logic [7:0] t;
    cols = "@ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    digs = $sformatf("%0d", mv[19:10]);
    exp_q.push_back(cols[int'(mv[9:0])]);
    for (int i = 0; i < digs.len(); i++) exp_q.push_back(digs[i]);
    case (mv[21:20])
      2'd0:    t = "+";
      2'd1:    t = "/";
      default: t = "\\";
    endcase
    exp_q.push_back(t);
    n = 2 + digs.len();
`ifdef TRAX_MOVE_TX_NEWLINE_EN
    exp_q.push_back(8'h0A);
    n++;
`endif
  endtask

  // Entered one cycle after the acceptance edge (k=1).
  task automatic wait_done(input string tag, input int n_chars, input int pulse_k, input int rst_k);
    int k, fall, nd, lim;
    k = 1;
    fall = 0;
    lim = 12 + 10*n_chars*C + 50;
    check({tag, "_busy_start"}, busy, 1);
    while (done !== 1'b1 && k < lim) begin
      if (tx === 1'b0 && fall == 0) fall = k;
      if (k == pulse_k) begin
        start_transmit = 1'b1;
        move_in = 22'h100005;
      end
      if (k == pulse_k + 1) start_transmit = 1'b0;
      if (k == rst_k) begin
        reset = 1'b1;
        abort_gen++;
        tick;
        exp_q.delete();
        reset = 1'b0;
        check({tag, "_rst_tx"}, tx, 1);
        check({tag, "_rst_busy"}, busy, 0);
        nd = (done === 1'b1) ? 1 : 0;
        repeat (50) begin
          tick;
          if (done !== 1'b0) nd++;
        end
        check({tag, "_rst_no_done"}, nd, 0);
        return;
      end
      tick;
      k++;
    end
    check({tag, "_tx_fall"}, fall, 12);
    check({tag, "_done_cycle"}, k, 12 + 10*n_chars*C);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_tx_at_done"}, tx, 1);
  endtask

  task automatic run_frame(input string tag, input logic [21:0] mv, input int pulse_k, input int rst_k);
    int n;
    push_exp(mv, n);
    move_in = mv;
    start_transmit = 1'b1;
    tick;
    start_transmit = 1'b0;
    wait_done(tag, n, pulse_k, rst_k);
    tick;
    tick;
  endtask

  task automatic run_illegal(input string tag, input logic [21:0] mv);
    int bad;
    move_in = mv;
    start_transmit = 1'b1;
    tick;
    start_transmit = 1'b0;
    check({tag, "_err"}, err, 1);
    check({tag, "_busy"}, busy, 0);
    tick;
    check({tag, "_err_once"}, err, 0);
    bad = 0;
    repeat (499) begin
      tick;
      if (tx !== 1'b1 || busy !== 1'b0 || err !== 1'b0) bad++;
    end
    check({tag, "_quiet"}, bad, 0);
  endtask

  initial begin
    int n, z;
    logic [21:0] mv;
    repeat (3) tick;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    tick;

    run_frame("f_r1c1", 22'h000401, -1, -1);
    run_frame("f_r1023c26", 22'h2FFC1A, -1, -1);
    run_frame("f_r0c0", 22'h100000, -1, -1);
    run_frame("f_r1000", {2'd2, 10'd1000, 10'd0}, -1, -1);
    run_illegal("ill_col", 22'h00001B);
    run_illegal("ill_tile", 22'h300401);
    run_frame("pulse", {2'd1, 10'd57, 10'd5}, 30, -1);

    mv = {2'd0, 10'd200, 10'd13};
    push_exp(mv, n);
    push_exp(mv, n);
    move_in = mv;
    start_transmit = 1'b1;
    tick;
    wait_done("b2b_a", n, -1, -1);
    z = 0;
    while (busy !== 1'b1 && z < 10) begin
      z++;
      tick;
    end
    check("b2b_gap", z, 2);
    start_transmit = 1'b0;
    wait_done("b2b_b", n, -1, -1);
    tick;
    tick;

    run_frame("rst", 22'h2FFC1A, -1, 12 + 12*C + 1);
    run_frame("after_rst", 22'h000401, -1, -1);

    repeat (5) tick;
    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
